// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// wait-counter width and the byte-lane address helper.
package dmem_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic [2:0] S_RST_EXIT = 3'd0;
   localparam logic [2:0] S_IDLE     = 3'd1;
   localparam logic [2:0] S_RD_WAIT  = 3'd2;
   localparam logic [2:0] S_RD_RSP   = 3'd3;
   localparam logic [2:0] S_WR_REC   = 3'd4;

   typedef enum logic [2:0] {
      RST_EXIT = S_RST_EXIT,
      IDLE     = S_IDLE,
      RD_WAIT  = S_RD_WAIT,
      RD_RSP   = S_RD_RSP,
      WR_REC   = S_WR_REC
   } state_t;

   // Number of byte-offset address bits below the word index.
   function automatic int unsigned lane_bits(input int unsigned data_width);
      return (data_width <= 8) ? 0 : $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Word array with per-byte write enables; one synchronous write port and
// one asynchronous read port. Contents are never reset.
module dmem_bytelane_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned INDEX_BITS = 10
) (
   input  logic                    clk,
   input  logic                    i_we,
   input  logic [INDEX_BITS-1:0]   i_waddr,
   input  logic [DATA_WIDTH/8-1:0] i_wbe,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [INDEX_BITS-1:0]   i_raddr,
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   localparam int unsigned LANES = DATA_WIDTH / 8;
   localparam int unsigned DEPTH = 1 << INDEX_BITS;

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int unsigned b = 0; b < LANES; b++) begin
            if (i_wbe[b]) begin
               r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// RAM-side responder for the arbiter's data-memory port: accepts level-held
// requests in IDLE, applies read latency / write recovery, flags bad addresses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDRESS_BITS   = 32,
   parameter int unsigned INDEX_BITS     = 10,
   parameter int unsigned READ_LATENCY   = 2,
   parameter int unsigned WRITE_RECOVERY = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    d_mem_read,
   input  logic                    d_mem_write,
   input  logic [DATA_WIDTH/8-1:0] d_mem_byte_en,
   input  logic [ADDRESS_BITS-1:0] d_mem_address_in,
   input  logic [DATA_WIDTH-1:0]   d_mem_data_in,
   output logic [DATA_WIDTH-1:0]   d_mem_data_out,
   output logic [ADDRESS_BITS-1:0] d_mem_address_out,
   output logic                    d_mem_valid,
   output logic                    d_mem_ready,
   output logic                    access_fault
);

   localparam int unsigned LANES = DATA_WIDTH / 8;
   localparam int unsigned LB    = lane_bits(DATA_WIDTH);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LOAD =
      CNT_W'((WRITE_RECOVERY == 0) ? 0 : WRITE_RECOVERY - 1);

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [INDEX_BITS-1:0]   r_idx;
   logic [LANES-1:0]        r_be;
   logic                    r_oor;
   logic [ADDRESS_BITS-1:0] r_addr;
   logic                    r_ready;
   logic                    r_valid;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [ADDRESS_BITS-1:0] r_addr_out;
   logic                    r_fault;

   logic [INDEX_BITS-1:0]   w_idx;
   logic                    w_oor;
   logic                    w_we;
   logic [DATA_WIDTH-1:0]   w_ram_rdata;
   logic [DATA_WIDTH-1:0]   w_rd_masked;

   assign w_idx = d_mem_address_in[INDEX_BITS+LB-1:LB];
   assign w_oor = |(d_mem_address_in >> (INDEX_BITS + LB));

   // Writes commit on the accepting edge itself; read has precedence.
   assign w_we = (r_state == IDLE) && d_mem_write && !d_mem_read && !w_oor;

   dmem_bytelane_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .INDEX_BITS (INDEX_BITS)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_idx),
      .i_wbe   (d_mem_byte_en),
      .i_wdata (d_mem_data_in),
      .i_raddr (r_idx),
      .o_rdata (w_ram_rdata)
   );

   always_comb begin
      w_rd_masked = '0;
      for (int unsigned b = 0; b < LANES; b++) begin
         if (r_be[b]) begin
            w_rd_masked[b*8 +: 8] = w_ram_rdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= RST_EXIT;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_be       <= '0;
         r_oor      <= 1'b0;
         r_addr     <= '0;
         r_ready    <= 1'b0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_addr_out <= '0;
         r_fault    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            RST_EXIT: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
            IDLE: begin
               if (d_mem_read) begin
                  r_idx   <= w_idx;
                  r_be    <= d_mem_byte_en;
                  r_oor   <= w_oor;
                  r_addr  <= d_mem_address_in;
                  r_cnt   <= RD_LOAD;
                  r_ready <= 1'b0;
                  r_state <= RD_WAIT;
                  if (w_oor) r_fault <= 1'b1;
               end else if (d_mem_write) begin
                  r_addr_out <= d_mem_address_in;
                  if (w_oor) r_fault <= 1'b1;
                  if (WRITE_RECOVERY != 0) begin
                     r_cnt   <= WR_LOAD;
                     r_ready <= 1'b0;
                     r_state <= WR_REC;
                  end
               end
            end
            RD_WAIT: begin
               if (r_cnt == '0) begin
                  r_data     <= r_oor ? '0 : w_rd_masked;
                  r_addr_out <= r_addr;
                  r_valid    <= 1'b1;
                  r_state    <= RD_RSP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RD_RSP: begin
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            WR_REC: begin
               if (r_cnt == '0) begin
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_ready <= 1'b0;
               r_state <= RST_EXIT;
            end
         endcase
      end
   end

   assign d_mem_data_out    = r_data;
   assign d_mem_address_out = r_addr_out;
   assign d_mem_valid       = r_valid;
   assign d_mem_ready       = r_ready;
   assign access_fault      = r_fault;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

   localparam int unsigned RL = 2;
   localparam int unsigned WR = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        d_mem_read = 1'b0;
   logic        d_mem_write = 1'b0;
   logic [3:0]  d_mem_byte_en = '0;
   logic [31:0] d_mem_address_in = '0;
   logic [31:0] d_mem_data_in = '0;
   logic [31:0] d_mem_data_out;
   logic [31:0] d_mem_address_out;
   logic        d_mem_valid;
   logic        d_mem_ready;
   logic        access_fault;

   always #5 clk = ~clk;

   dmem_responder #(
      .DATA_WIDTH     (32),
      .ADDRESS_BITS   (32),
      .INDEX_BITS     (10),
      .READ_LATENCY   (RL),
      .WRITE_RECOVERY (WR)
   ) u_dut (
      .clk               (clk),
      .reset             (reset),
      .d_mem_read        (d_mem_read),
      .d_mem_write       (d_mem_write),
      .d_mem_byte_en     (d_mem_byte_en),
      .d_mem_address_in  (d_mem_address_in),
      .d_mem_data_in     (d_mem_data_in),
      .d_mem_data_out    (d_mem_data_out),
      .d_mem_address_out (d_mem_address_out),
      .d_mem_valid       (d_mem_valid),
      .d_mem_ready       (d_mem_ready),
      .access_fault      (access_fault)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model: the 16 words the stimulus touches, plus the sticky fault.
   logic [31:0] m_mem [16];
   logic        m_fault = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // 1024 words of 4 bytes: anything at or above 4 KiB is out of range.
   function automatic bit is_oor(input logic [31:0] a);
      return (a >= 32'd4096);
   endfunction

   function automatic int unsigned widx(input logic [31:0] a);
      return (a % 4096) / 4;
   endfunction

   function automatic logic [31:0] rd_model(input int unsigned i, input logic [3:0] be);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = m_mem[i][8*b +: 8];
      return r;
   endfunction

   task automatic wait_ready(input string tag);
      int unsigned n;
      n = 0;
      while (!d_mem_ready && n < 64) begin
         n++;
         @(negedge clk);
      end
      chk(tag, d_mem_ready, 1'b1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int unsigned low;
      int unsigned i;
      wait_ready("wr_idle");
      d_mem_write      = 1'b1;
      d_mem_address_in = a;
      d_mem_data_in    = d;
      d_mem_byte_en    = be;
      @(negedge clk);
      d_mem_write      = 1'b0;
      d_mem_address_in = $urandom;
      d_mem_data_in    = $urandom;
      if (is_oor(a)) begin
         m_fault = 1'b1;
      end else begin
         i = widx(a);
         for (int b = 0; b < 4; b++)
            if (be[b]) m_mem[i][8*b +: 8] = d[8*b +: 8];
      end
      chk("wr_addr_echo", d_mem_address_out, a);
      chk("wr_fault", access_fault, m_fault);
      low = 0;
      while (!d_mem_ready && low < 40) begin
         low++;
         @(negedge clk);
      end
      chk("wr_recovery", low, WR);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [3:0] be, input bit with_wr,
                          output logic [31:0] got);
      logic [31:0] exp;
      int unsigned lat;
      wait_ready("rd_idle");
      d_mem_read       = 1'b1;
      d_mem_write      = with_wr;
      d_mem_address_in = a;
      d_mem_byte_en    = be;
      d_mem_data_in    = $urandom;
      @(negedge clk);
      d_mem_write      = 1'b0;
      d_mem_address_in = $urandom;
      d_mem_byte_en    = 4'($urandom);
      if (is_oor(a)) begin
         m_fault = 1'b1;
         exp = '0;
      end else begin
         exp = rd_model(widx(a), be);
      end
      lat = 0;
      while (!d_mem_valid && lat < 40) begin
         lat++;
         chk("rd_busy", d_mem_ready, 1'b0);
         @(negedge clk);
      end
      chk("rd_latency", lat, RL);
      got = d_mem_data_out;
      chk("rd_data", got, exp);
      chk("rd_addr_echo", d_mem_address_out, a);
      chk("rd_fault", access_fault, m_fault);
      d_mem_read = 1'b0;
      @(negedge clk);
      chk("rd_valid_1cyc", d_mem_valid, 1'b0);
      chk("rd_ready_back", d_mem_ready, 1'b1);
      chk("rd_data_hold", d_mem_data_out, exp);
   endtask

   task automatic reset_seq();
      reset       = 1'b1;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      m_fault     = 1'b0;
      @(negedge clk);
      chk("rst_ready", d_mem_ready, 1'b0);
      chk("rst_valid", d_mem_valid, 1'b0);
      chk("rst_data", d_mem_data_out, 32'h0);
      chk("rst_addr", d_mem_address_out, 32'h0);
      chk("rst_fault", access_fault, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rel_ready_c1", d_mem_ready, 1'b0);
      @(negedge clk);
      chk("rel_ready_c2", d_mem_ready, 1'b1);
      chk("rel_valid", d_mem_valid, 1'b0);
      chk("rel_data", d_mem_data_out, 32'h0);
      chk("rel_addr", d_mem_address_out, 32'h0);
      chk("rel_fault", access_fault, 1'b0);
   endtask

   function automatic logic [31:0] rand_addr();
      return 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
   endfunction

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      int unsigned op;

      @(negedge clk);
      reset_seq();

      for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 4'hF);

      do_write(32'h10, 32'hDEADBEEF, 4'hF);
      do_read(32'h10, 4'hF, 1'b0, got);
      chk("dir_beef", got, 32'hDEADBEEF);
      chk("dir_beef_addr", d_mem_address_out, 32'h10);

      do_write(32'h20, 32'hAAAAAAAA, 4'hF);
      do_write(32'h20, 32'h11223344, 4'h5);
      do_read(32'h20, 4'hF, 1'b0, got);
      chk("be_merge", got, 32'hAA22AA44);

      do_write(32'h24, 32'h01020304, 4'hF);
      do_write(32'h28, 32'h05060708, 4'hF);

      do_read(32'h20, 4'hF, 1'b1, got);
      do_read(32'h20, 4'hF, 1'b0, got);
      chk("rd_precedence", got, 32'hAA22AA44);

      for (int n = 0; n < 150; n++) begin
         op = $urandom_range(0, 9);
         a  = rand_addr();
         if (op == 9) a = a | (32'h1 << $urandom_range(12, 31));
         if (op <= 3 || (op == 9 && $urandom_range(0, 1) == 0))
            do_write(a, $urandom, 4'($urandom));
         else
            do_read(a, 4'($urandom), (op == 8), got);
      end

      do_read(32'h0001_0000, 4'hF, 1'b0, got);
      chk("oor_data", got, 32'h0);
      chk("oor_fault", access_fault, 1'b1);
      do_write(32'h30, 32'h55AA55AA, 4'hF);
      do_read(32'h30, 4'hF, 1'b0, got);
      chk("fault_sticky", access_fault, 1'b1);

      do_write(32'h10, 32'hCAFEF00D, 4'hF);
      wait_ready("mid_idle");
      d_mem_read       = 1'b1;
      d_mem_address_in = 32'h10;
      d_mem_byte_en    = 4'hF;
      @(negedge clk);
      chk("mid_busy", d_mem_ready, 1'b0);
      chk("mid_valid_pre", d_mem_valid, 1'b0);
      reset_seq();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("mid_no_valid", d_mem_valid, 1'b0);
      end
      do_read(32'h10, 4'hF, 1'b0, got);
      chk("mid_keep", got, 32'hCAFEF00D);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 0) do_write(rand_addr(), $urandom, 4'($urandom));
         else do_read(rand_addr(), 4'($urandom), 1'b0, got);
      end
      chk("post_rst_fault", access_fault, 1'b0);
      do_write(32'h8000_0000, 32'h12345678, 4'hF);
      chk("oor_wr_fault", access_fault, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
